// File: rtl/uart_cmd_frame_ctrl.sv
//------------------------------------------------------------------------------
// uart_cmd_frame_ctrl
//
// Command-frame controller that sits behind the single-byte UART receiver.
// It assembles frames of the form
//    HEAD0, HEAD1, ADDR, DATA_H, DATA_L, SUM      (SUM = ADDR+DATA_H+DATA_L mod 256)
// and turns each good frame into a single-cycle register-write command.
// Frames with a bad checksum, or frames that stall longer than TIMEOUT_CLKS
// between bytes, are discarded and flagged with a Frame_Err pulse. Err_Cnt
// keeps a saturating tally of those pulses.
//
// Ports:
//    Clk        in   system clock
//    Rst_n      in   asynchronous active-low reset
//    Rx_Byte    in   [7:0]  received byte, qualified by Rx_Done
//    Rx_Done    in   one-cycle byte-received strobe
//    Reg_Wr     out  one-cycle register write strobe
//    Reg_Addr   out  [7:0]  register address, valid with Reg_Wr and held
//    Reg_Data   out  [15:0] register data, valid with Reg_Wr and held
//    Frame_Err  out  one-cycle pulse on checksum mismatch or timeout
//    Err_Cnt    out  [7:0]  saturating count of Frame_Err pulses
//    Busy       out  high while a frame is in progress
//------------------------------------------------------------------------------
module uart_cmd_frame_ctrl #(
   parameter int unsigned TIMEOUT_CLKS = 500000,
   parameter int unsigned TMO_W        = 20,
   parameter logic [7:0]  HEAD0        = 8'h55,
   parameter logic [7:0]  HEAD1        = 8'hA5
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [7:0]  Rx_Byte,
   input  logic        Rx_Done,
   output logic        Reg_Wr,
   output logic [7:0]  Reg_Addr,
   output logic [15:0] Reg_Data,
   output logic        Frame_Err,
   output logic [7:0]  Err_Cnt,
   output logic        Busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_H1   = 3'd1,
      S_ADDR = 3'd2,
      S_DH   = 3'd3,
      S_DL   = 3'd4,
      S_SUM  = 3'd5
   } state_t;

   localparam int unsigned      TMO_LAST_I = TIMEOUT_CLKS - 32'd1;
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_LAST_I[TMO_W-1:0];
   localparam logic [TMO_W-1:0] TMO_ONE    = {{(TMO_W-1){1'b0}}, 1'b1};

   // 8-bit modular add used for the frame checksum
   function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
      add8 = a + b;
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   logic [TMO_W-1:0]  tmo_cnt_r;
   logic [7:0]        sum_r;
   logic [7:0]        addr_r;
   logic [15:0]       data_r;
   logic              wr_nxt_s;
   logic              err_nxt_s;
   logic              tmo_exp_s;

   // A byte arriving in the expiry cycle takes priority, hence the !Rx_Done term
   assign tmo_exp_s = (state_r != S_IDLE) && !Rx_Done && (tmo_cnt_r == TMO_LAST);

   // State register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode plus write/error strobe requests
   always_comb begin
      state_nxt_s = state_r;
      wr_nxt_s    = 1'b0;
      err_nxt_s   = 1'b0;
      if (Rx_Done) begin
         case (state_r)
            S_IDLE: begin
               if (Rx_Byte == HEAD0) begin
                  state_nxt_s = S_H1;
               end else begin
                  state_nxt_s = S_IDLE;
               end
            end
            S_H1: begin
               // A repeated HEAD0 is treated as a fresh frame start
               if (Rx_Byte == HEAD1) begin
                  state_nxt_s = S_ADDR;
               end else if (Rx_Byte == HEAD0) begin
                  state_nxt_s = S_H1;
               end else begin
                  state_nxt_s = S_IDLE;
               end
            end
            S_ADDR:  state_nxt_s = S_DH;
            S_DH:    state_nxt_s = S_DL;
            S_DL:    state_nxt_s = S_SUM;
            S_SUM: begin
               state_nxt_s = S_IDLE;
               if (Rx_Byte == sum_r) begin
                  wr_nxt_s = 1'b1;
               end else begin
                  err_nxt_s = 1'b1;
               end
            end
            default: state_nxt_s = S_IDLE;
         endcase
      end else if (tmo_exp_s) begin
         state_nxt_s = S_IDLE;
         err_nxt_s   = 1'b1;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Inter-byte timeout counter: runs only while a frame is open
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (Rx_Done || (state_r == S_IDLE) || tmo_exp_s) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else begin
         tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
      end
   end

   // Field capture and running checksum
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sum_r  <= 8'h00;
         addr_r <= 8'h00;
         data_r <= 16'h0000;
      end else if (Rx_Done) begin
         case (state_r)
            S_H1: begin
               if (Rx_Byte == HEAD1) begin
                  sum_r <= 8'h00;
               end else begin
                  sum_r <= sum_r;
               end
            end
            S_ADDR: begin
               addr_r <= Rx_Byte;
               sum_r  <= add8(sum_r, Rx_Byte);
            end
            S_DH: begin
               data_r[15:8] <= Rx_Byte;
               sum_r        <= add8(sum_r, Rx_Byte);
            end
            S_DL: begin
               data_r[7:0] <= Rx_Byte;
               sum_r       <= add8(sum_r, Rx_Byte);
            end
            default: begin
               sum_r <= sum_r;
            end
         endcase
      end else begin
         sum_r <= sum_r;
      end
   end

   // Registered outputs; Reg_Addr/Reg_Data only move on a good frame
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Reg_Wr    <= 1'b0;
         Reg_Addr  <= 8'h00;
         Reg_Data  <= 16'h0000;
         Frame_Err <= 1'b0;
         Err_Cnt   <= 8'h00;
         Busy      <= 1'b0;
      end else begin
         Reg_Wr    <= wr_nxt_s;
         Frame_Err <= err_nxt_s;
         Busy      <= (state_nxt_s != S_IDLE);
         if (wr_nxt_s) begin
            Reg_Addr <= addr_r;
            Reg_Data <= data_r;
         end else begin
            Reg_Addr <= Reg_Addr;
            Reg_Data <= Reg_Data;
         end
         if (err_nxt_s && (Err_Cnt != 8'hFF)) begin
            Err_Cnt <= Err_Cnt + 8'h01;
         end else begin
            Err_Cnt <= Err_Cnt;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_frame_ctrl.sv
//------------------------------------------------------------------------------
// Testbench for uart_cmd_frame_ctrl. Uses a short timeout so expiry fits in
// a quick run. Expected values come from the frame rules: checksum is the
// byte sum mod 256, a good frame yields one write, a bad one one error.
//------------------------------------------------------------------------------
module tb_uart_cmd_frame_ctrl;

   localparam int T = 64;

   logic        Clk;
   logic        Rst_n;
   logic [7:0]  Rx_Byte;
   logic        Rx_Done;
   logic        Reg_Wr;
   logic [7:0]  Reg_Addr;
   logic [15:0] Reg_Data;
   logic        Frame_Err;
   logic [7:0]  Err_Cnt;
   logic        Busy;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_pulses = 0;
   int err_pulses = 0;
   int exp_err = 0;
   logic [7:0]  exp_addr = 8'h00;
   logic [15:0] exp_data = 16'h0000;

   uart_cmd_frame_ctrl #(.TIMEOUT_CLKS(T)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Rx_Byte(Rx_Byte), .Rx_Done(Rx_Done),
      .Reg_Wr(Reg_Wr), .Reg_Addr(Reg_Addr), .Reg_Data(Reg_Data),
      .Frame_Err(Frame_Err), .Err_Cnt(Err_Cnt), .Busy(Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // pulse tally and exclusivity watch
   always @(negedge Clk) begin
      if (Reg_Wr) wr_pulses++;
      if (Frame_Err) err_pulses++;
      if (Reg_Wr || Frame_Err) begin
         n_cmp++;
         if (Reg_Wr && Frame_Err) begin
            n_bad++;
            $display("FAIL wr_err_exclusive: Reg_Wr=%b Frame_Err=%b, required not both", Reg_Wr, Frame_Err);
         end
      end
   end

   function automatic int sat_add(input int a, input int b);
      sat_add = (a + b > 255) ? 255 : a + b;
   endfunction

   // one byte strobe; called and returns at a falling edge
   task automatic send_byte(input logic [7:0] b);
      Rx_Byte = b;
      Rx_Done = 1'b1;
      @(negedge Clk);
      Rx_Done = 1'b0;
      Rx_Byte = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                             input logic [7:0] dl, input logic [7:0] s);
      send_byte(8'h55); send_byte(8'hA5); send_byte(a);
      send_byte(dh); send_byte(dl); send_byte(s);
   endtask

   task automatic test_reset();
      Rst_n = 1'b0; Rx_Done = 1'b0; Rx_Byte = 8'h00;
      idle(3);
      n_cmp++;
      if ({Reg_Wr, Reg_Addr, Reg_Data, Frame_Err, Err_Cnt, Busy} !== 35'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h required 0",
                  {Reg_Wr, Reg_Addr, Reg_Data, Frame_Err, Err_Cnt, Busy});
      end
      Rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_good_frame();
      send_byte(8'h55);
      n_cmp++;
      if (Busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_frame: got %b required 1", Busy); end
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h9C);
      exp_addr = 8'h12; exp_data = 16'h3456;
      n_cmp++;
      if ({Reg_Wr, Frame_Err} !== 2'b10) begin n_bad++; $display("FAIL good_strobes: got wr/err %b required 10", {Reg_Wr, Frame_Err}); end
      n_cmp++;
      if (Reg_Addr !== exp_addr || Reg_Data !== exp_data) begin
         n_bad++; $display("FAIL good_payload: got %h/%h required %h/%h", Reg_Addr, Reg_Data, exp_addr, exp_data);
      end
      idle(1);
      n_cmp++;
      if ({Reg_Wr, Busy} !== 2'b00) begin n_bad++; $display("FAIL good_after: got wr/busy %b required 00", {Reg_Wr, Busy}); end
   endtask

   task automatic test_bad_checksum();
      send_frame(8'h12, 8'h34, 8'h56, 8'h9D);
      exp_err = sat_add(exp_err, 1);
      n_cmp++;
      if ({Reg_Wr, Frame_Err} !== 2'b01) begin n_bad++; $display("FAIL bad_strobes: got wr/err %b required 01", {Reg_Wr, Frame_Err}); end
      n_cmp++;
      if (Reg_Addr !== exp_addr || Reg_Data !== exp_data) begin
         n_bad++; $display("FAIL bad_hold: got %h/%h required %h/%h", Reg_Addr, Reg_Data, exp_addr, exp_data);
      end
      idle(1);
      n_cmp++;
      if (Err_Cnt !== 8'(exp_err)) begin n_bad++; $display("FAIL bad_errcnt: got %0d required %0d", Err_Cnt, exp_err); end
   endtask

   task automatic test_resync();
      send_byte(8'h55); send_byte(8'h55); send_byte(8'hA5); send_byte(8'h01);
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h00);
      exp_addr = 8'h01; exp_data = 16'h00FF;
      n_cmp++;
      if (Reg_Wr !== 1'b1 || Reg_Addr !== exp_addr || Reg_Data !== exp_data) begin
         n_bad++; $display("FAIL resync: got wr=%b %h/%h required 1 %h/%h", Reg_Wr, Reg_Addr, Reg_Data, exp_addr, exp_data);
      end
      idle(2);
   endtask

   task automatic test_timeout();
      send_byte(8'h55); send_byte(8'hA5); send_byte(8'h07);
      idle(T - 1);
      n_cmp++;
      if (Frame_Err !== 1'b0 || Busy !== 1'b1) begin
         n_bad++; $display("FAIL tmo_early: got err/busy %b required 01", {Frame_Err, Busy});
      end
      idle(1);
      exp_err = sat_add(exp_err, 1);
      n_cmp++;
      if (Frame_Err !== 1'b1 || Busy !== 1'b0) begin
         n_bad++; $display("FAIL tmo_expire: got err/busy %b required 10", {Frame_Err, Busy});
      end
      idle(1);
      n_cmp++;
      if (Err_Cnt !== 8'(exp_err) || Frame_Err !== 1'b0) begin
         n_bad++; $display("FAIL tmo_errcnt: got %0d err=%b required %0d 0", Err_Cnt, Frame_Err, exp_err);
      end
      send_frame(8'h07, 8'h00, 8'h01, 8'h08);
      exp_addr = 8'h07; exp_data = 16'h0001;
      n_cmp++;
      if (Reg_Wr !== 1'b1 || Reg_Data !== exp_data) begin
         n_bad++; $display("FAIL tmo_recover: got wr=%b %h required 1 %h", Reg_Wr, Reg_Data, exp_data);
      end
      idle(2);
   endtask

   task automatic test_expiry_boundary();
      int e0;
      e0 = err_pulses;
      send_byte(8'h55); send_byte(8'hA5); send_byte(8'h2C);
      idle(T - 1);
      send_byte(8'h81);
      send_byte(8'h02);
      idle(T - 1);
      send_byte(8'hAF);
      exp_addr = 8'h2C; exp_data = 16'h8102;
      n_cmp++;
      if (Reg_Wr !== 1'b1 || Reg_Addr !== exp_addr || Reg_Data !== exp_data) begin
         n_bad++; $display("FAIL boundary_frame: got wr=%b %h/%h required 1 %h/%h", Reg_Wr, Reg_Addr, Reg_Data, exp_addr, exp_data);
      end
      n_cmp++;
      if (err_pulses - e0 !== 0) begin n_bad++; $display("FAIL boundary_noerr: got %0d err pulses required 0", err_pulses - e0); end
      idle(2);
   endtask

   task automatic test_random();
      logic [7:0] a, dh, dl, s, g;
      bit bad;
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            g = 8'($urandom);
            if (g == 8'h55) g = 8'h54;
            send_byte(g);
            idle($urandom_range(0, 3));
         end
         a = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
         s = 8'((int'(a) + int'(dh) + int'(dl)) % 256);
         bad = ($urandom_range(0, 3) == 0);
         if (bad) s = s ^ 8'($urandom_range(1, 255));
         send_byte(8'h55); idle($urandom_range(0, 5));
         send_byte(8'hA5); idle($urandom_range(0, 5));
         send_byte(a);     idle($urandom_range(0, 5));
         send_byte(dh);    idle($urandom_range(0, 5));
         send_byte(dl);    idle($urandom_range(0, 5));
         send_byte(s);
         if (!bad) begin exp_addr = a; exp_data = {dh, dl}; end
         else exp_err = sat_add(exp_err, 1);
         n_cmp++;
         if (Reg_Wr !== !bad || Frame_Err !== bad) begin
            n_bad++; $display("FAIL rnd_strobes[%0d]: got wr/err %b%b required %b%b", i, Reg_Wr, Frame_Err, !bad, bad);
         end
         n_cmp++;
         if (Reg_Addr !== exp_addr || Reg_Data !== exp_data) begin
            n_bad++; $display("FAIL rnd_payload[%0d]: got %h/%h required %h/%h", i, Reg_Addr, Reg_Data, exp_addr, exp_data);
         end
         idle(1);
         n_cmp++;
         if (Err_Cnt !== 8'(exp_err) || Busy !== 1'b0) begin
            n_bad++; $display("FAIL rnd_errcnt[%0d]: got %0d busy=%b required %0d 0", i, Err_Cnt, Busy, exp_err);
         end
      end
   endtask

   task automatic test_back_to_back();
      int w0;
      w0 = wr_pulses;
      send_frame(8'h30, 8'h11, 8'h22, 8'h63);
      n_cmp++;
      if (Reg_Wr !== 1'b1 || Reg_Data !== 16'h1122) begin n_bad++; $display("FAIL b2b_first: got wr=%b %h required 1 1122", Reg_Wr, Reg_Data); end
      send_frame(8'h31, 8'hF0, 8'h20, 8'h41);
      exp_addr = 8'h31; exp_data = 16'hF020;
      n_cmp++;
      if (Reg_Wr !== 1'b1 || Reg_Addr !== exp_addr || Reg_Data !== exp_data) begin
         n_bad++; $display("FAIL b2b_second: got wr=%b %h/%h required 1 %h/%h", Reg_Wr, Reg_Addr, Reg_Data, exp_addr, exp_data);
      end
      idle(1);
      n_cmp++;
      if (wr_pulses - w0 !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d writes required 2", wr_pulses - w0); end
   endtask

   task automatic test_saturation();
      int e0;
      e0 = err_pulses;
      for (int i = 0; i < 300; i++) send_frame(8'h01, 8'h02, 8'h03, 8'h07);
      exp_err = sat_add(exp_err, 300);
      idle(2);
      n_cmp++;
      if (Err_Cnt !== 8'hFF || exp_err != 255) begin n_bad++; $display("FAIL sat_errcnt: got %h required ff", Err_Cnt); end
      n_cmp++;
      if (err_pulses - e0 !== 300) begin n_bad++; $display("FAIL sat_pulses: got %0d required 300", err_pulses - e0); end
   endtask

   task automatic test_midframe_reset();
      int w0, e0;
      send_byte(8'h55); send_byte(8'hA5); send_byte(8'h21);
      Rx_Byte = 8'h43; Rx_Done = 1'b1; Rst_n = 1'b0;
      @(negedge Clk);
      Rx_Done = 1'b0;
      exp_err = 0; exp_addr = 8'h00; exp_data = 16'h0000;
      n_cmp++;
      if ({Reg_Wr, Reg_Addr, Reg_Data, Frame_Err, Err_Cnt, Busy} !== 35'd0) begin
         n_bad++; $display("FAIL midreset_outputs: got %h required 0", {Reg_Wr, Reg_Addr, Reg_Data, Frame_Err, Err_Cnt, Busy});
      end
      idle(2);
      Rst_n = 1'b1;
      w0 = wr_pulses; e0 = err_pulses;
      idle(1);
      send_byte(8'h10); send_byte(8'h74);
      idle(T + 4);
      n_cmp++;
      if (wr_pulses != w0 || err_pulses != e0 || Busy !== 1'b0 || Reg_Addr !== exp_addr) begin
         n_bad++; $display("FAIL midreset_discard: got wr=%0d err=%0d busy=%b addr=%h required 0 0 0 00",
                           wr_pulses - w0, err_pulses - e0, Busy, Reg_Addr);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_resync();
      test_timeout();
      test_expiry_boundary();
      test_random();
      test_back_to_back();
      test_saturation();
      test_midframe_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_cmd_frame_ctrl.md
Name: uart_cmd_frame_ctrl

Overview:
Command-frame controller placed after the single-byte UART receiver in the uart_scope design. It consumes the receiver's byte stream (byte plus one-cycle done strobe), runs a header/address/data/checksum frame state machine with an inter-byte timeout, and issues single-cycle register-write commands that configure the scope (trigger level, sample rate, channel enable, etc.). Malformed or stalled frames are discarded, flagged, and counted.

Parameters:
TIMEOUT_CLKS, 500000, max Clk cycles allowed between bytes inside a frame (10 ms at 50 MHz); width of timeout counter = 20 bits
HEAD0, 8'h55, first header byte
HEAD1, 8'hA5, second header byte

Ports:
Clk  input  1  system clock, 50 MHz
Rst_n  input  1  asynchronous active-low reset
Rx_Byte  input  8  received byte, valid in the cycle Rx_Done is high
Rx_Done  input  1  one-cycle strobe, byte received
Reg_Wr  output  1  one-cycle write strobe to scope register bank
Reg_Addr  output  8  register address, valid with Reg_Wr, held afterwards
Reg_Data  output  16  register data, valid with Reg_Wr, held afterwards
Frame_Err  output  1  one-cycle pulse on checksum mismatch or timeout
Err_Cnt  output  8  saturating count of Frame_Err pulses
Busy  output  1  high whenever state != S_IDLE

Behaviour:
- Reset: one clock; reset asynchronous, active-low. All outputs 0, state S_IDLE, timeout counter 0, internal addr/data/checksum registers 0.
- Frame format: HEAD0, HEAD1, ADDR, DATA_H, DATA_L, SUM; SUM = (ADDR + DATA_H + DATA_L) mod 256.
- Bytes are acted on only in cycles with Rx_Done=1; Rx_Byte is ignored otherwise.
- States and transitions (on Rx_Done):
  - S_IDLE: byte==HEAD0 -> S_H1; otherwise stay.
  - S_H1: byte==HEAD1 -> S_ADDR; byte==HEAD0 -> stay S_H1 (resync); otherwise -> S_IDLE. No error is flagged.
  - S_ADDR: latch addr, -> S_DH.
  - S_DH: latch data[15:8], -> S_DL.
  - S_DL: latch data[7:0], -> S_SUM.
  - S_SUM: compare byte with the 8-bit running sum. Match: Reg_Wr=1 next cycle and Reg_Addr/Reg_Data update in that same cycle. Mismatch: Frame_Err=1 next cycle and Reg_Addr/Reg_Data stay unchanged. Both cases -> S_IDLE.
- Latency: Reg_Wr or Frame_Err asserts exactly 1 cycle after the Rx_Done carrying SUM.
- Running sum: cleared on entry to S_ADDR; adds ADDR, DATA_H and DATA_L with 8-bit wrap.
- Timeout:
  - Counter clears on every Rx_Done and is held at 0 in S_IDLE.
  - It increments each cycle in any other state.
  - When it reaches TIMEOUT_CLKS-1 with no Rx_Done: -> S_IDLE, Frame_Err pulses 1 cycle, counter clears.
  - If Rx_Done coincides with the expiry cycle, the byte wins: it is processed normally and no timeout occurs.
- S_H1 timeout is also an error.
- Err_Cnt increments on each Frame_Err and saturates at 8'hFF. It clears only on reset.
- Reg_Wr and Frame_Err are never high in the same cycle.
- Back-to-back frames with zero idle between them are accepted. A HEAD0 arriving the cycle after SUM is handled, because S_IDLE is already entered.
- Reset asserted mid-frame: immediate return to reset state and the partial frame is discarded; no Reg_Wr or Frame_Err results.

Test Plan:
- Frame 55 A5 12 34 56 9C -> single Reg_Wr 1 cycle after last Rx_Done, Reg_Addr=8'h12, Reg_Data=16'h3456, Frame_Err=0, Busy low afterward.
- Frame 55 A5 12 34 56 9D -> Frame_Err pulse, Err_Cnt=1, no Reg_Wr, Reg_Addr/Reg_Data keep previous values.
- Bytes 55 55 A5 01 00 FF 00 -> resync accepted; Reg_Wr with Reg_Addr=8'h01, Reg_Data=16'h00FF (sum 8'h00, wrap checked).
- Frame 55 A5 07 then no byte for TIMEOUT_CLKS cycles -> Frame_Err at expiry, state S_IDLE. A subsequent full frame 55 A5 07 00 01 08 -> Reg_Wr, Reg_Data=16'h0001.
- Rx_Done with next byte placed exactly on the expiry cycle -> no Frame_Err; frame completes normally.
- 300 bad-checksum frames -> Err_Cnt=8'hFF and saturated. Rst_n low during DATA_H of a valid frame -> all outputs 0, no Reg_Wr.
